// File: rtl/mem_ram_pkg.sv
// Shared encodings for the byte-addressable RAM controller.
package mem_ram_pkg;

   // Load size/extension selector.
   typedef enum logic [2:0] {
      LD_LW  = 3'b000,
      LD_LH  = 3'b001,
      LD_LHU = 3'b010,
      LD_LB  = 3'b011,
      LD_LBU = 3'b100
   } load_mode_e;

   // Store size selector; ST_BAD is never a legal store.
   typedef enum logic [1:0] {
      ST_SW  = 2'b00,
      ST_SH  = 2'b01,
      ST_SB  = 2'b10,
      ST_BAD = 2'b11
   } store_mode_e;

   // Controller states.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_RESP = 2'b10
   } state_e;

endpackage

// File: rtl/mem_ram_align.sv
// Combinational lane steering: legality check, store byte enables and
// load extraction/extension for one big-endian 32-bit memory row.
// Lane k of a row word lives in bits [31-8k -: 8]; wr_be[3-k] enables lane k.
module mem_ram_align
   import mem_ram_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic        is_read,
   input  logic        is_write,
   input  logic [2:0]  load_mode,
   input  logic [1:0]  store_mode,
   input  logic [31:0] write_data,
   input  logic [31:0] rd_word,
   output logic        err,
   output logic [3:0]  wr_be,
   output logic [31:0] wr_word,
   output logic [31:0] load_data
);

   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   // Pick the addressed halfword and byte out of the row word.
   always_comb begin
      half_sel = addr_lo[1] ? rd_word[15:0] : rd_word[31:16];
      byte_sel = rd_word[31:24];
      case (addr_lo)
         2'd0:    byte_sel = rd_word[31:24];
         2'd1:    byte_sel = rd_word[23:16];
         2'd2:    byte_sel = rd_word[15:8];
         default: byte_sel = rd_word[7:0];
      endcase
   end

   // Decode the request; any illegal combination suppresses all writes and data.
   always_comb begin
      err       = 1'b0;
      wr_be     = 4'b0000;
      wr_word   = write_data;
      load_data = 32'h0;
      if (is_read == is_write) begin
         err = 1'b1;
      end else if (is_read) begin
         case (load_mode_e'(load_mode))
            LD_LW: begin
               err       = (addr_lo != 2'b00);
               load_data = rd_word;
            end
            LD_LH: begin
               err       = addr_lo[0];
               load_data = {{16{half_sel[15]}}, half_sel};
            end
            LD_LHU: begin
               err       = addr_lo[0];
               load_data = {16'h0, half_sel};
            end
            LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  load_data = {24'h0, byte_sel};
            default: err = 1'b1;
         endcase
      end else begin
         case (store_mode_e'(store_mode))
            ST_SW: begin
               err   = (addr_lo != 2'b00);
               wr_be = 4'b1111;
            end
            ST_SH: begin
               err     = addr_lo[0];
               wr_word = {2{write_data[15:0]}};
               wr_be   = addr_lo[1] ? 4'b0011 : 4'b1100;
            end
            ST_SB: begin
               wr_word = {4{write_data[7:0]}};
               wr_be   = 4'b1000 >> addr_lo;
            end
            default: err = 1'b1;
         endcase
      end
      if (err) begin
         wr_be     = 4'b0000;
         load_data = 32'h0;
      end
   end

endmodule

// File: rtl/mem_ram_ctrl.sv
// Single-port byte RAM controller with programmable wait states.
// Storage is four byte-wide banks (one per lane of a 32-bit row) so every
// legal access touches a single row. The bank read is registered on the
// access edge, formatted during RESP and published with resp_valid on the
// following edge, giving WAIT_CYCLES+2 edges from accept to response.
module mem_ram_ctrl
   import mem_ram_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  load_mode,
   input  logic [1:0]  store_mode,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        resp_valid,
   output logic        resp_err
);

   localparam int ROWS = 2 ** (ADDR_W - 2);

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                is_rd_q, is_rd_d, is_wr_q, is_wr_d;
   logic [2:0]          lmode_q, lmode_d;
   logic [1:0]          smode_q, smode_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         read_data_q, read_data_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_err_q, resp_err_d;

   logic                access;
   logic [ADDR_W-3:0]   row;
   logic [31:0]         rd_word;
   logic                err;
   logic [3:0]          wr_be;
   logic [31:0]         wr_word;
   logic [31:0]         load_data;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^address[31:ADDR_W];
   assign row    = addr_q[ADDR_W-1:2];
   assign access = (state_q == S_WAIT) && (cnt_q == 4'd0);

   mem_ram_align u_align (
      .addr_lo    (addr_q[1:0]),
      .is_read    (is_rd_q),
      .is_write   (is_wr_q),
      .load_mode  (lmode_q),
      .store_mode (smode_q),
      .write_data (wdata_q),
      .rd_word    (rd_word),
      .err        (err),
      .wr_be      (wr_be),
      .wr_word    (wr_word),
      .load_data  (load_data)
   );

   // One byte bank per lane; reset gates the access so an aborted store never commits.
   for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      logic [7:0] mem_q [ROWS];
      logic [7:0] rd_byte_q;

      // Bank write and registered read on the access edge.
      always_ff @(posedge clk) begin
         if (rst_n && access) begin
            if (wr_be[3-gi]) begin
               mem_q[row] <= wr_word[31-8*gi -: 8];
            end
            rd_byte_q <= mem_q[row];
         end
      end

      assign rd_word[31-8*gi -: 8] = rd_byte_q;
   end

   // Next-state, request latch and response formatting.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      is_rd_d      = is_rd_q;
      is_wr_d      = is_wr_q;
      lmode_d      = lmode_q;
      smode_d      = smode_q;
      wdata_d      = wdata_q;
      read_data_d  = read_data_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = address[ADDR_W-1:0];
               is_rd_d = mem_read;
               is_wr_d = mem_write;
               lmode_d = load_mode;
               smode_d = store_mode;
               wdata_d = write_data;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            resp_valid_d = 1'b1;
            resp_err_d   = err;
            if (err) begin
               read_data_d = 32'h0;
            end else if (is_rd_q) begin
               read_data_d = load_data;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         addr_q       <= '0;
         is_rd_q      <= 1'b0;
         is_wr_q      <= 1'b0;
         lmode_q      <= 3'd0;
         smode_q      <= 2'd0;
         wdata_q      <= 32'h0;
         read_data_q  <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         is_rd_q      <= is_rd_d;
         is_wr_q      <= is_wr_d;
         lmode_q      <= lmode_d;
         smode_q      <= smode_d;
         wdata_q      <= wdata_d;
         read_data_q  <= read_data_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign read_data  = read_data_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_ram_ctrl.sv
// Self-checking bench for mem_ram_ctrl: directed vector table, hand-built
// reset-abort and ignored-request sequences, then random traffic checked
// against a byte-array reference model.
module tb_mem_ram_ctrl;

   localparam int ADDR_W    = 10;
   localparam int WAIT      = 3;
   localparam int MEM_BYTES = 1 << ADDR_W;
   localparam int NV        = 20;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  load_mode;
   logic [1:0]  store_mode;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        resp_valid;
   logic        resp_err;

   int checks = 0;
   int errors = 0;

   logic [7:0]  ref_mem [MEM_BYTES];
   logic [31:0] ref_rd;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  lm;
      logic [1:0]  sm;
      logic [31:0] a;
      logic [31:0] wd;
      logic        e;
      logic [31:0] r;
   } vec_t;

   vec_t vecs [NV];

   mem_ram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .load_mode  (load_mode),
      .store_mode (store_mode),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .resp_valid (resp_valid),
      .resp_err   (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %08h want %08h", nm, act, exp);
      end
   endtask

   // Reference model: flat byte array, big-endian, from the access rules directly.
   task automatic model_apply(input logic rd, input logic wr, input logic [2:0] lm,
                              input logic [1:0] sm, input logic [31:0] a,
                              input logic [31:0] wd, output logic e, output logic [31:0] r);
      int base;
      int size;
      logic [31:0] v;
      base = int'(a % MEM_BYTES);
      e    = 1'b0;
      size = 1;
      if (rd == wr) e = 1'b1;
      else if (rd) begin
         case (lm)
            3'd0:       size = 4;
            3'd1, 3'd2: size = 2;
            3'd3, 3'd4: size = 1;
            default:    e = 1'b1;
         endcase
      end else begin
         case (sm)
            2'd0:    size = 4;
            2'd1:    size = 2;
            2'd2:    size = 1;
            default: e = 1'b1;
         endcase
      end
      if (!e && (base % size) != 0) e = 1'b1;
      if (e) begin
         r = 32'h0;
      end else if (rd) begin
         v = 32'h0;
         for (int i = 0; i < size; i++) v = {v[23:0], ref_mem[base + i]};
         if (lm == 3'd1 && v[15]) v = v | 32'hFFFF0000;
         if (lm == 3'd3 && v[7])  v = v | 32'hFFFFFF00;
         r = v;
      end else begin
         for (int i = 0; i < size; i++) ref_mem[base + i] = wd[8*(size-1-i) +: 8];
         r = ref_rd;
      end
      ref_rd = r;
   endtask

   // Issue one request and wait (bounded) for its response.
   task automatic do_txn(input logic rd, input logic wr, input logic [2:0] lm,
                         input logic [1:0] sm, input logic [31:0] a, input logic [31:0] wd,
                         output logic got_e, output logic [31:0] got_r);
      int n;
      @(negedge clk);
      chk("ready_before", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      mem_read   = rd;
      mem_write  = wr;
      load_mode  = lm;
      store_mode = sm;
      address    = a;
      write_data = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", 32'(n), 32'(WAIT + 2));
      got_e = resp_err;
      got_r = read_data;
   endtask

   task automatic run_check(input string nm, input logic rd, input logic wr, input logic [2:0] lm,
                            input logic [1:0] sm, input logic [31:0] a, input logic [31:0] wd,
                            input logic exp_e, input logic [31:0] exp_r);
      logic        ge;
      logic [31:0] gr;
      do_txn(rd, wr, lm, sm, a, wd, ge, gr);
      $display("txn %s rd=%0b wr=%0b lm=%0d sm=%0d a=%08h wd=%08h -> err=%0b data=%08h", nm, rd, wr,
               lm, sm, a, wd, ge, gr);
      chk({nm, "_err"}, 32'(ge), 32'(exp_e));
      chk({nm, "_data"}, gr, exp_r);
      @(posedge clk);
      #1;
      chk({nm, "_pulse"}, 32'(resp_valid), 32'd0);
      chk({nm, "_hold"}, read_data, exp_r);
   endtask

   function automatic vec_t mk(logic rd, logic wr, logic [2:0] lm, logic [1:0] sm, logic [31:0] a,
                               logic [31:0] wd, logic e, logic [31:0] r);
      vec_t v;
      v.rd = rd; v.wr = wr; v.lm = lm; v.sm = sm; v.a = a; v.wd = wd; v.e = e; v.r = r;
      return v;
   endfunction

   initial begin
      logic        de;
      logic [31:0] dr;
      logic        rd;
      logic        wr;
      logic [2:0]  lm;
      logic [1:0]  sm;
      logic [31:0] a;
      logic [31:0] wd;
      int          sel;
      int          hits;

      vecs[0]  = mk(0, 1, 0, 0, 32'h10,       32'hDEADBEEF, 0, 32'h00000000);
      vecs[1]  = mk(1, 0, 0, 0, 32'h10,       32'h0,        0, 32'hDEADBEEF);
      vecs[2]  = mk(1, 0, 1, 0, 32'h10,       32'h0,        0, 32'hFFFFDEAD);
      vecs[3]  = mk(1, 0, 2, 0, 32'h12,       32'h0,        0, 32'h0000BEEF);
      vecs[4]  = mk(1, 0, 3, 0, 32'h13,       32'h0,        0, 32'hFFFFFFEF);
      vecs[5]  = mk(1, 0, 4, 0, 32'h11,       32'h0,        0, 32'h000000AD);
      vecs[6]  = mk(0, 1, 0, 2, 32'h11,       32'h00000055, 0, 32'h000000AD);
      vecs[7]  = mk(1, 0, 0, 0, 32'h10,       32'h0,        0, 32'hDE55BEEF);
      vecs[8]  = mk(1, 0, 0, 0, 32'h12,       32'h0,        1, 32'h00000000);
      vecs[9]  = mk(0, 1, 0, 1, 32'h13,       32'h0000AAAA, 1, 32'h00000000);
      vecs[10] = mk(1, 0, 0, 0, 32'h10,       32'h0,        0, 32'hDE55BEEF);
      vecs[11] = mk(1, 1, 0, 0, 32'h10,       32'h0,        1, 32'h00000000);
      vecs[12] = mk(0, 0, 0, 0, 32'h10,       32'h0,        1, 32'h00000000);
      vecs[13] = mk(1, 0, 5, 0, 32'h10,       32'h0,        1, 32'h00000000);
      vecs[14] = mk(0, 1, 0, 3, 32'h10,       32'h00000011, 1, 32'h00000000);
      vecs[15] = mk(1, 0, 0, 0, 32'h10,       32'h0,        0, 32'hDE55BEEF);
      vecs[16] = mk(0, 1, 0, 1, 32'h12,       32'h00001234, 0, 32'hDE55BEEF);
      vecs[17] = mk(1, 0, 0, 0, 32'hFFFFFC10, 32'h0,        0, 32'hDE551234);
      vecs[18] = mk(1, 0, 1, 0, 32'h12,       32'h0,        0, 32'h00001234);
      vecs[19] = mk(1, 0, 3, 0, 32'h10,       32'h0,        0, 32'hFFFFFFDE);

      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
      ref_rd     = 32'h0;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      load_mode  = 3'd0;
      store_mode = 2'd0;
      address    = 32'h0;
      write_data = 32'h0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_data", read_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vector table.
      for (int i = 0; i < NV; i++) begin
         model_apply(vecs[i].rd, vecs[i].wr, vecs[i].lm, vecs[i].sm, vecs[i].a, vecs[i].wd, de, dr);
         run_check($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].lm, vecs[i].sm,
                   vecs[i].a, vecs[i].wd, vecs[i].e, vecs[i].r);
      end

      // Fill the random-traffic region so every later load is predictable.
      for (int w = 0; w < 32; w++) begin
         wd = $urandom;
         model_apply(1'b0, 1'b1, 3'd0, 2'd0, 32'(w * 4), wd, de, dr);
         run_check($sformatf("init%0d", w), 1'b0, 1'b1, 3'd0, 2'd0, 32'(w * 4), wd, de, dr);
      end

      // Reset during WAIT aborts a pending store.
      model_apply(1'b0, 1'b1, 3'd0, 2'd0, 32'h20, 32'hA5A5A5A5, de, dr);
      run_check("abort_pre", 1'b0, 1'b1, 3'd0, 2'd0, 32'h20, 32'hA5A5A5A5, de, dr);
      @(negedge clk);
      req_valid  = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b1;
      store_mode = 2'd0;
      address    = 32'h20;
      write_data = 32'h12345678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_valid", 32'(resp_valid), 32'd0);
      chk("abort_err", 32'(resp_err), 32'd0);
      chk("abort_data", read_data, 32'h0);
      chk("abort_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n  = 1'b1;
      ref_rd = 32'h0;
      hits   = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (resp_valid) hits++;
      end
      chk("abort_noresp", 32'(hits), 32'd0);
      model_apply(1'b1, 1'b0, 3'd0, 2'd0, 32'h20, 32'h0, de, dr);
      run_check("abort_post", 1'b1, 1'b0, 3'd0, 2'd0, 32'h20, 32'h0, de, dr);

      // Requests while busy are ignored; check ready/valid timing edge by edge.
      model_apply(1'b1, 1'b0, 3'd0, 2'd0, 32'h30, 32'h0, de, dr);
      @(negedge clk);
      chk("ign_ready0", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      mem_read   = 1'b1;
      mem_write  = 1'b0;
      load_mode  = 3'd0;
      address    = 32'h30;
      @(posedge clk);
      #1;
      mem_read   = 1'b0;
      mem_write  = 1'b1;
      store_mode = 2'd0;
      write_data = 32'hCAFEF00D;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("ign_ready_e%0d", k), 32'(req_ready), 32'd0);
         chk($sformatf("ign_valid_e%0d", k), 32'(resp_valid), 32'd0);
      end
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      $display("txn ign_lw a=00000030 -> valid=%0b err=%0b data=%08h", resp_valid, resp_err, read_data);
      chk("ign_valid_e5", 32'(resp_valid), 32'd1);
      chk("ign_err", 32'(resp_err), 32'(de));
      chk("ign_data", read_data, dr);
      chk("ign_ready_e5", 32'(req_ready), 32'd1);
      hits = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (resp_valid) hits++;
      end
      chk("ign_noextra", 32'(hits), 32'd0);
      model_apply(1'b1, 1'b0, 3'd0, 2'd0, 32'h30, 32'h0, de, dr);
      run_check("ign_post", 1'b1, 1'b0, 3'd0, 2'd0, 32'h30, 32'h0, de, dr);

      // Random traffic against the reference model.
      for (int t = 0; t < 300; t++) begin
         sel = $urandom_range(0, 9);
         rd  = (sel <= 3) || (sel == 8);
         wr  = (sel >= 4 && sel <= 8);
         lm  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
         sm  = 2'($urandom_range(0, 3));
         a   = {$urandom, 7'h0} | 32'($urandom_range(0, 127));
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         wd  = $urandom;
         model_apply(rd, wr, lm, sm, a, wd, de, dr);
         run_check($sformatf("rnd%0d", t), rd, wr, lm, sm, a, wd, de, dr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_ram_ctrl.md
MEM_RAM_CTRL -- requirements
Module: mem_ram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width; storage SHALL be 2**ADDR_W bytes.
REQ-002 Parameter WAIT_CYCLES, default 1, range 0..15, extra access wait states.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  controller can accept a request.
REQ-007 mem_read  in  1  request is a load.
REQ-008 mem_write  in  1  request is a store.
REQ-009 load_mode  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU.
REQ-010 store_mode  in  2  00 SW, 01 SH, 10 SB, 11 illegal.
REQ-011 address  in  32  byte address; only bits [ADDR_W-1:0] SHALL index storage (modulo wrap).
REQ-012 write_data  in  32  store data; SH uses [15:0], SB uses [7:0].
REQ-013 read_data  out  32  load result, registered.
REQ-014 resp_valid  out  1  one-cycle completion pulse.
REQ-015 resp_err  out  1  qualifies resp_valid; request rejected.

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 Accept = req_valid && req_ready; all request fields SHALL be latched at accept; IDLE->WAIT, wait counter loaded with WAIT_CYCLES.
REQ-018 WAIT: counter nonzero -> decrement, stay; counter zero -> perform access on that edge, go RESP.
REQ-019 RESP: resp_valid=1 for exactly one cycle, then IDLE; latency accept edge to resp_valid high = WAIT_CYCLES+2 edges.
REQ-020 Byte order big-endian: word at A = {mem[A],mem[A+1],mem[A+2],mem[A+3]}; halfword = {mem[A],mem[A+1]}.
REQ-021 LH/LB sign-extend from bit 15/7; LHU/LBU zero-extend.
REQ-022 Misalignment: word needs A[1:0]=00, half needs A[0]=0; misaligned -> resp_err=1.
REQ-023 Error also for: both mem_read and mem_write, neither set, load_mode 101-111 on read, store_mode 11 on write.
REQ-024 Error response SHALL write no byte and SHALL drive read_data=0.
REQ-025 Store: only addressed bytes written; read_data unchanged on successful store.
REQ-026 read_data SHALL hold its value between responses.
REQ-027 req_valid while not ready SHALL be ignored; no queueing.

Reset
REQ-028 rst_n=0 at an edge SHALL force IDLE, req_ready=1 after release, resp_valid=0, resp_err=0, read_data=0, counter=0.
REQ-029 Reset during WAIT SHALL abort the request; the pending store SHALL NOT commit.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-031 Package mem_ram_pkg SHALL hold load/store mode encodings and the FSM state enum.
REQ-032 Sub-module mem_ram_align SHALL perform combinational lane extraction, extension and alignment/legality check.

Verification
REQ-033 SW 0x00000010 data 0xDEADBEEF, then LW 0x10 -> read_data 0xDEADBEEF, resp_err 0.
REQ-034 After REQ-033: LH 0x10 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000BEEF; LB 0x13 -> 0xFFFFFFEF; LBU 0x11 -> 0x000000AD.
REQ-035 SB 0x11 data 0x00000055 then LW 0x10 -> 0xDE55BEEF.
REQ-036 LW 0x12 and SH 0x13 -> resp_err 1, read_data 0; subsequent LW 0x10 unchanged.
REQ-037 WAIT_CYCLES=3: accept at edge 0 -> resp_valid high only after edge 5, req_ready low edges 1-5, req_valid pulses then ignored.
REQ-038 SW 0x20 data 0x12345678, rst_n low during WAIT, then LW 0x20 -> previous contents, not 0x12345678.
